// File: rtl/fp_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : fp_div_iter
// Description : Iterative bfloat16 divider (C = A / B). Restoring division,
//               one quotient bit per cycle, round-to-nearest-even, denormal
//               flush-to-zero, NaN/Inf encodings shared with the FPU multiplier.
//               Valid/ready handshake on both the operand and result sides.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   QBITS       quotient bits produced (1 integer, 7 fraction, guard, extra);
//               must be >= 10, bits beyond 10 fold into the sticky bit
//   BIAS        exponent bias
// Ports
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   in_valid_i  operands valid
//   in_ready_o  divider idle, operands accepted when in_valid_i=1
//   a_i / b_i   dividend / divisor, bfloat16
//   abort_i     synchronous kill of the operation in flight
//   out_valid_o result valid, held until out_ready_i
//   out_ready_i consumer accepts result
//   result_o    quotient, bfloat16
//   flags_o     {NV,DZ,OF,UF,NX}, only with FPU_DIV_FLAGS_EN defined
// Build option
//   FPU_DIV_FLAGS_EN : adds the flags_o port and its flag logic.
// ============================================================================
module fp_div_iter #(
    parameter int QBITS = 10,
    parameter int BIAS  = 127
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        abort_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] result_o
`ifdef FPU_DIV_FLAGS_EN
    ,
    output logic [4:0]  flags_o
`endif
);

    localparam int CW = $clog2(QBITS + 1);
    localparam logic [CW-1:0] C_LAST_CNT = CW'(QBITS - 1);
    // Quotient bits below the guard position, for each normalisation case.
    localparam logic [QBITS-1:0] C_MASK_HI = ~({QBITS{1'b1}} << (QBITS - 9));
    localparam logic [QBITS-1:0] C_MASK_LO = ~({QBITS{1'b1}} << (QBITS - 10));
    localparam logic [15:0] C_QNAN = 16'h7FC0;
    localparam logic [14:0] C_INF  = 15'h7F80;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [8:0]         rem_q, rem_d;
    logic [7:0]         sigb_q, sigb_d;
    logic [QBITS-1:0]   quo_q, quo_d;
    logic signed [9:0]  exp_q, exp_d;
    logic               sign_q, sign_d;
    logic [15:0]        res_q, res_d;

    // ------------------------------------------------------------------
    // Operand classification
    // ------------------------------------------------------------------
    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic w_sign, w_spec;
    logic [15:0] w_spec_res;
    logic signed [9:0] w_exp_acc;

    always_comb begin
        // Exponent field 0 is treated as zero regardless of the mantissa.
        w_a_zero = (a_i[14:7] == 8'h00);
        w_b_zero = (b_i[14:7] == 8'h00);
        w_a_inf  = (a_i[14:7] == 8'hFF) && (a_i[6:0] == 7'h00);
        w_b_inf  = (b_i[14:7] == 8'hFF) && (b_i[6:0] == 7'h00);
        w_a_nan  = (a_i[14:7] == 8'hFF) && (a_i[6:0] != 7'h00);
        w_b_nan  = (b_i[14:7] == 8'hFF) && (b_i[6:0] != 7'h00);
        w_sign   = a_i[15] ^ b_i[15];
        w_spec   = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;

        w_spec_res = 16'h0000;
        if (w_a_nan || w_b_nan) begin
            w_spec_res = C_QNAN;
        end else if ((w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
            w_spec_res = C_QNAN;
        end else if (w_a_inf) begin
            w_spec_res = {w_sign, C_INF};
        end else if (w_b_zero) begin
            w_spec_res = {w_sign, C_INF};
        end else begin
            // 0/x and x/Inf both give +0.
            w_spec_res = 16'h0000;
        end

        w_exp_acc = $signed({2'b00, a_i[14:7]}) - $signed({2'b00, b_i[14:7]})
                  + $signed(10'(BIAS));
    end

`ifdef FPU_DIV_FLAGS_EN
    logic [4:0] w_spec_flags;
    always_comb begin
        w_spec_flags = 5'b00000;
        if (w_a_nan || w_b_nan) begin
            w_spec_flags = 5'b00000;
        end else if ((w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
            w_spec_flags = 5'b10000;
        end else if (w_a_inf) begin
            w_spec_flags = 5'b00000;
        end else if (w_b_zero) begin
            w_spec_flags = 5'b01000;
        end
    end
`endif

    // ------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------
    logic       w_qbit;
    logic [8:0] w_rem_rest;

    always_comb begin
        w_qbit     = (rem_q >= {1'b0, sigb_q});
        w_rem_rest = w_qbit ? (rem_q - {1'b0, sigb_q}) : rem_q;
    end

    // ------------------------------------------------------------------
    // Normalise, round to nearest-even, range check
    // ------------------------------------------------------------------
    logic              w_int;
    logic [6:0]        w_mant;
    logic              w_guard, w_sticky, w_inc;
    logic [7:0]        w_mant_sum;
    logic signed [9:0] w_exp_pre, w_exp_rnd;
    logic [6:0]        w_mant_rnd;
    logic              w_of, w_uf;
    logic [15:0]       w_round_res;

    always_comb begin
        w_int = quo_q[QBITS-1];
        if (w_int) begin
            w_mant    = quo_q[QBITS-2 -: 7];
            w_guard   = quo_q[QBITS-9];
            w_sticky  = (|(quo_q & C_MASK_HI)) | (|rem_q);
            w_exp_pre = exp_q;
        end else begin
            // Quotient below 1.0: shift up one place and lower the exponent.
            w_mant    = quo_q[QBITS-3 -: 7];
            w_guard   = quo_q[QBITS-10];
            w_sticky  = (|(quo_q & C_MASK_LO)) | (|rem_q);
            w_exp_pre = exp_q - 10'sd1;
        end

        w_inc      = w_guard & (w_sticky | w_mant[0]);
        w_mant_sum = {1'b0, w_mant} + {7'd0, w_inc};
        if (w_mant_sum[7]) begin
            w_mant_rnd = 7'h00;
            w_exp_rnd  = w_exp_pre + 10'sd1;
        end else begin
            w_mant_rnd = w_mant_sum[6:0];
            w_exp_rnd  = w_exp_pre;
        end

        w_of = (w_exp_rnd >= 10'sd255);
        w_uf = (w_exp_rnd <= 10'sd0);

        if (w_of) begin
            w_round_res = {sign_q, C_INF};
        end else if (w_uf) begin
            w_round_res = 16'h0000;
        end else begin
            w_round_res = {sign_q, w_exp_rnd[7:0], w_mant_rnd};
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
`ifdef FPU_DIV_FLAGS_EN
    logic [4:0] flags_q, flags_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        sigb_d  = sigb_q;
        quo_d   = quo_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        res_d   = res_q;
`ifdef FPU_DIV_FLAGS_EN
        flags_d = flags_q;
`endif

        if (abort_i) begin
            // Kill wins over everything, including an accept this cycle.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        sign_d = w_sign;
                        if (w_spec) begin
                            res_d   = w_spec_res;
`ifdef FPU_DIV_FLAGS_EN
                            flags_d = w_spec_flags;
`endif
                            state_d = S_DONE;
                        end else begin
                            rem_d   = {2'b01, a_i[6:0]};
                            sigb_d  = {1'b1, b_i[6:0]};
                            quo_d   = '0;
                            cnt_d   = '0;
                            exp_d   = w_exp_acc;
                            state_d = S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    // Remainder stays below 2*divisor, so 9 bits never overflow.
                    rem_d = w_rem_rest << 1;
                    quo_d = {quo_q[QBITS-2:0], w_qbit};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == C_LAST_CNT) begin
                        state_d = S_ROUND;
                    end
                end
                S_ROUND: begin
                    res_d   = w_round_res;
`ifdef FPU_DIV_FLAGS_EN
                    flags_d = {2'b00, w_of, w_uf, w_guard | w_sticky | w_of | w_uf};
`endif
                    state_d = S_DONE;
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            sigb_q  <= '0;
            quo_q   <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            res_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            sigb_q  <= sigb_d;
            quo_q   <= quo_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            res_q   <= res_d;
        end
    end

`ifdef FPU_DIV_FLAGS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_q <= 5'b00000;
        end else begin
            flags_q <= flags_d;
        end
    end
    assign flags_o = flags_q;
`endif

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign result_o    = res_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_div_iter
// Description : Self-checking bench for fp_div_iter. Directed vector table
//               plus hand-written stall, abort and mid-operation reset runs.
//               Flag checks are compiled in with FPU_DIV_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_div_iter;

    localparam int QBITS   = 10;
    localparam int LAT_N   = QBITS + 2;
    localparam int LAT_S   = 1;
    localparam int TIMEOUT = 200;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        abort_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] result_o;
`ifdef FPU_DIV_FLAGS_EN
    logic [4:0]  flags_o;
`endif

    fp_div_iter #(.QBITS(QBITS), .BIAS(127)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .abort_i     (abort_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o)
`ifdef FPU_DIV_FLAGS_EN
        ,
        .flags_o     (flags_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one operand pair and returns after the accept edge (+1).
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        while (!in_ready_o && n < TIMEOUT) begin
            @(posedge clk_i); #1; n++;
        end
        check("in_ready before accept", {31'd0, in_ready_o}, 32'd1);
        a_i = a; b_i = b; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    // Counts edges from the accept edge (inclusive) until out_valid_o rises.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid_o && lat < TIMEOUT) begin
            @(posedge clk_i); #1; lat++;
        end
    endtask

    task automatic handshake();
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        int          lat;
        logic [4:0]  flags;   // {NV,DZ,OF,UF,NX}
    } vec_t;

    vec_t vecs[17];

    initial begin
        int lat;
        logic seen;

        vecs[0]  = '{16'h4040, 16'h4000, 16'h3FC0, LAT_N, 5'b00000}; // 3/2
        vecs[1]  = '{16'h3F80, 16'h4040, 16'h3EAB, LAT_N, 5'b00001}; // 1/3 rounds up
        vecs[2]  = '{16'h3F80, 16'h0000, 16'h7F80, LAT_S, 5'b01000}; // 1/0
        vecs[3]  = '{16'h0000, 16'h0000, 16'h7FC0, LAT_S, 5'b10000}; // 0/0
        vecs[4]  = '{16'h7FC0, 16'h3F80, 16'h7FC0, LAT_S, 5'b00000}; // NaN/1
        vecs[5]  = '{16'h7F00, 16'h3F00, 16'h7F80, LAT_N, 5'b00101}; // overflow
        vecs[6]  = '{16'h3F80, 16'h3F80, 16'h3F80, LAT_N, 5'b00000}; // 1/1
        vecs[7]  = '{16'h40A0, 16'h4000, 16'h4020, LAT_N, 5'b00000}; // 5/2
        vecs[8]  = '{16'hC040, 16'h4000, 16'hBFC0, LAT_N, 5'b00000}; // -3/2
        vecs[9]  = '{16'h3F80, 16'h3FC0, 16'h3F2B, LAT_N, 5'b00001}; // 1/1.5
        vecs[10] = '{16'h0080, 16'h7F00, 16'h0000, LAT_N, 5'b00011}; // underflow
        vecs[11] = '{16'h7F80, 16'h7F80, 16'h7FC0, LAT_S, 5'b10000}; // Inf/Inf
        vecs[12] = '{16'h7F80, 16'hBF80, 16'hFF80, LAT_S, 5'b00000}; // Inf/-1
        vecs[13] = '{16'h3F80, 16'h7F80, 16'h0000, LAT_S, 5'b00000}; // 1/Inf
        vecs[14] = '{16'h3F80, 16'h8000, 16'hFF80, LAT_S, 5'b01000}; // 1/-0
        vecs[15] = '{16'h0001, 16'h3F80, 16'h0000, LAT_S, 5'b00000}; // denormal/1
        vecs[16] = '{16'h4040, 16'h3FC0, 16'h4000, LAT_N, 5'b00000}; // 3/1.5

        rst_ni = 1'b0; in_valid_i = 1'b0; a_i = '0; b_i = '0;
        abort_i = 1'b0; out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset out_valid", {31'd0, out_valid_o}, 32'd0);
        check("reset in_ready",  {31'd0, in_ready_o},  32'd1);
        check("reset result",    {16'd0, result_o},    32'h0000);
`ifdef FPU_DIV_FLAGS_EN
        check("reset flags",     {27'd0, flags_o},     32'd0);
`endif
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // ---------------- vector table ----------------
        for (int i = 0; i < 17; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_valid(lat);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d result %h/%h", i, vecs[i].a, vecs[i].b),
                  {16'd0, result_o}, {16'd0, vecs[i].res});
`ifdef FPU_DIV_FLAGS_EN
            check($sformatf("vec%0d flags", i), {27'd0, flags_o}, {27'd0, vecs[i].flags});
`endif
            handshake();
            check($sformatf("vec%0d out_valid after handshake", i), {31'd0, out_valid_o}, 32'd0);
        end

        // ---------------- back-pressure in DONE ----------------
        start_op(16'h3F80, 16'h4040);
        wait_valid(lat);
        check("stall latency", lat, LAT_N);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            check("stall result stable", {16'd0, result_o}, 32'h3EAB);
            check("stall out_valid held", {31'd0, out_valid_o}, 32'd1);
            check("stall in_ready low", {31'd0, in_ready_o}, 32'd0);
        end
        // Offer a new operand during the output handshake: it must not be taken.
        a_i = 16'h4040; b_i = 16'h4000; in_valid_i = 1'b1; out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        check("release out_valid drops", {31'd0, out_valid_o}, 32'd0);
        check("release back to idle", {31'd0, in_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        check("single transfer (no hidden accept)", {31'd0, in_ready_o}, 32'd1);
        check("single transfer out_valid", {31'd0, out_valid_o}, 32'd0);

        // ---------------- abort priority over accept ----------------
        a_i = 16'h3F80; b_i = 16'h0000; in_valid_i = 1'b1; abort_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0; abort_i = 1'b0;
        check("abort beats accept", {31'd0, in_ready_o}, 32'd1);

        // ---------------- abort in 4th DIV cycle ----------------
        start_op(16'h3F80, 16'h4040);
        repeat (3) @(posedge clk_i);
        #1;
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        check("abort -> idle", {31'd0, in_ready_o}, 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid_o) seen = 1'b1;
            @(posedge clk_i); #1;
        end
        check("abort delivers nothing", {31'd0, seen}, 32'd0);
        start_op(16'h4040, 16'h4000);
        wait_valid(lat);
        check("post-abort latency", lat, LAT_N);
        check("post-abort result", {16'd0, result_o}, 32'h3FC0);
        handshake();

        // ---------------- reset in 4th DIV cycle ----------------
        start_op(16'h3F80, 16'h4040);
        repeat (3) @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid-op reset in_ready", {31'd0, in_ready_o}, 32'd1);
        check("mid-op reset out_valid", {31'd0, out_valid_o}, 32'd0);
        check("mid-op reset result", {16'd0, result_o}, 32'h0000);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid_o) seen = 1'b1;
            @(posedge clk_i); #1;
        end
        check("reset delivers nothing", {31'd0, seen}, 32'd0);
        start_op(16'h4040, 16'h4000);
        wait_valid(lat);
        check("post-reset latency", lat, LAT_N);
        check("post-reset result", {16'd0, result_o}, 32'h3FC0);
        handshake();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
